ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 159 +++++++++++++++
 tb/tb_ex_muldiv.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Multiply/divide execution unit: single-cycle 2*XLEN multiply, restoring
// radix-2 divide over XLEN iterations, result held until consumed downstream.
module ex_muldiv #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       a_i,
  input  logic [XLEN-1:0]       b_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [XLEN-1:0]       data_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o
);

  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   rem_q;
  logic              neg_quo;
  logic              neg_rem;
  logic [CNT_W-1:0]  cnt;

  logic              a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, bypass_res;
  logic              a_sx, b_sx;
  logic [2*XLEN-1:0] pa, pb, prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     r_sh, diff;
  logic              fits;
  logic [XLEN-1:0]   rem_nx, quo_nx, div_res;

  always_comb begin
    ready_o = (state == IDLE) && rst;
  end

  // Accept-time decode: signed ops are op_i[0]==0; op_i[1] selects remainder.
  always_comb begin
    a_neg      = !op_i[0] && a_i[XLEN-1];
    b_neg      = !op_i[0] && b_i[XLEN-1];
    a_mag      = a_neg ? -a_i : a_i;
    b_mag      = b_neg ? -b_i : b_i;
    div_zero   = (b_i == '0);
    div_ovf    = !op_i[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
    bypass_res = '0;
    if (div_zero)
      bypass_res = op_i[1] ? a_i : '1;
    else
      bypass_res = op_i[1] ? '0 : a_i;
  end

  // Sign-extend to 2*XLEN; the low 2*XLEN product bits are then exact for every signedness mix.
  always_comb begin
    a_sx    = ((op_q == 2'b01) || (op_q == 2'b10)) && a_q[XLEN-1];
    b_sx    = (op_q == 2'b01) && b_q[XLEN-1];
    pa      = {{XLEN{a_sx}}, a_q};
    pb      = {{XLEN{b_sx}}, b_q};
    prod    = pa * pb;
    mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // One restoring step: a_q shifts quotient bits in as the dividend shifts out.
  always_comb begin
    r_sh    = {rem_q, a_q[XLEN-1]};
    diff    = r_sh - {1'b0, b_q};
    fits    = !diff[XLEN];
    rem_nx  = fits ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    quo_nx  = {a_q[XLEN-2:0], fits};
    div_res = op_q[1] ? (neg_rem ? -rem_nx : rem_nx)
                      : (neg_quo ? -quo_nx : quo_nx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      cnt     <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      wd_o    <= '0;
      wreg_o  <= 1'b0;
    end else if (flush_i) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            op_q   <= op_i[1:0];
            wd_o   <= wd_i;
            wreg_o <= wreg_i;
            if (!op_i[2]) begin
              a_q   <= a_i;
              b_q   <= b_i;
              state <= MUL;
            end else if (div_zero || div_ovf) begin
              data_o  <= bypass_res;
              valid_o <= 1'b1;
              state   <= DONE;
            end else begin
              a_q     <= a_mag;
              b_q     <= b_mag;
              rem_q   <= '0;
              neg_quo <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              cnt     <= '0;
              state   <= DIV;
            end
          end
        end
        MUL: begin
          data_o  <= mul_res;
          valid_o <= 1'b1;
          state   <= DONE;
        end
        DIV: begin
          a_q   <= quo_nx;
          rem_q <= rem_nx;
          if (cnt == LAST_ITER) begin
            cnt     <= '0;
            data_o  <= div_res;
            valid_o <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: 32-bit main instance plus a 16-bit instance
// for the narrow-datapath divide latency.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0, wreg_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] a_i = '0, b_i = '0;
  logic [4:0]  wd_i = '0;
  logic        ready_o, valid_o, wreg_o;
  logic [31:0] data_o;
  logic [4:0]  wd_o;

  logic        flush16 = 1'b0, valid16 = 1'b0, ready16_i = 1'b0;
  logic [2:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ready16_o, valid16_o, wreg16_o;
  logic [15:0] data16_o;
  logic [4:0]  wd16_o;

  ex_muldiv #(.XLEN(32), .REG_ADDR_W(5)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .wd_o(wd_o), .wreg_o(wreg_o)
  );

  ex_muldiv #(.XLEN(16), .REG_ADDR_W(5)) u_dut16 (
    .clk(clk), .rst(rst), .flush_i(flush16), .valid_i(valid16), .ready_o(ready16_o),
    .op_i(op16), .a_i(a16), .b_i(b16), .wd_i(5'd3), .wreg_i(1'b1),
    .valid_o(valid16_o), .ready_i(ready16_i), .data_o(data16_o), .wd_o(wd16_o), .wreg_o(wreg16_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  wd;
    logic        wreg;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb_ = longint'($signed(b));
    longint unsigned ua = {32'h0, a};
    longint unsigned ub = {32'h0, b};
    longint          p;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: return a * b;
      3'd1: begin p = sa * sb_;          return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = longint'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb_; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb_; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int unsigned exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Accept edge is the posedge inside; returns at accept edge + 1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic wreg, input bit push);
    exp_t e;
    @(negedge clk);
    op_i = op; a_i = a; b_i = b; wd_i = wd; wreg_i = wreg; valid_i = 1'b1;
    check("ready_before_accept", ready_o, 1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    a_i = $urandom; b_i = $urandom; op_i = 3'($urandom); wd_i = 5'($urandom);
    if (push) begin
      e.data = model(op, a, b); e.wd = wd; e.wreg = wreg; e.lat = exp_lat(op, a, b);
      sb.push_back(e);
    end
  endtask

  task automatic collect(input int unsigned hold);
    exp_t        e;
    int unsigned lat = 1;
    while (!valid_o && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    e = sb.pop_front();
    check("latency", lat, e.lat);
    check("data", data_o, e.data);
    check("wd", wd_o, e.wd);
    check("wreg", wreg_o, e.wreg);
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", valid_o, 1);
      check("hold_data", data_o, e.data);
      check("hold_wd", {wreg_o, wd_o}, {e.wreg, e.wd});
      check("hold_ready", ready_o, 0);
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check("valid_after_consume", valid_o, 0);
    check("ready_after_consume", ready_o, 1);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b, 5'($urandom), 1'($urandom), 1'b1);
    collect(0);
  endtask

  task automatic div16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp);
    int unsigned lat = 1;
    @(negedge clk);
    op16 = op; a16 = a; b16 = b; valid16 = 1'b1;
    @(posedge clk); #1;
    valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    while (!valid16_o && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("x16_latency", lat, 17);
    check("x16_data", data16_o, exp);
    ready16_i = 1'b1;
    @(posedge clk); #1;
    ready16_i = 1'b0;
    check("x16_ready_after", ready16_o, 1);
  endtask

  initial begin
    logic seen;
    #2;
    check("rst_ready", ready_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_tag", {wreg_o, wd_o}, 0);
    @(negedge clk); rst = 1'b1;

    run(3'd1, 32'hFFFF_FFFF, 32'h2);
    run(3'd3, 32'hFFFF_FFFF, 32'h2);
    run(3'd4, 32'hFFFF_FFF9, 32'h2);
    run(3'd6, 32'hFFFF_FFF9, 32'h2);
    run(3'd5, 32'd100, 32'h0);
    run(3'd7, 32'd100, 32'h0);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);

    for (int i = 0; i < 24; i++)
      run(3'($urandom_range(0, 7)), pick(), pick());

    // Back-pressure: result must sit unchanged while ready_i is low.
    issue(3'd0, 32'd6, 32'd7, 5'd21, 1'b1, 1'b1);
    collect(5);

    // Flush during the divide loop.
    issue(3'd5, 32'd1000, 32'd3, 5'd9, 1'b1, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk); flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    check("flush_valid", valid_o, 0);
    check("flush_ready", ready_o, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1; seen |= valid_o;
    end
    check("flush_no_valid", seen, 0);
    issue(3'd0, 32'd3, 32'd5, 5'd4, 1'b1, 1'b1);
    check("mul_3x5_model", sb[0].data, 32'd15);
    collect(0);

    // Asynchronous reset mid-divide, away from any clock edge.
    issue(3'd4, 32'd12345, 32'd7, 5'd17, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_ready", ready_o, 0);
    check("arst_data", data_o, 0);
    check("arst_tag", {wreg_o, wd_o}, 0);
    @(posedge clk); #2 rst = 1'b1;
    run(3'd0, 32'd11, 32'd13);

    div16(3'd4, 16'hFFF9, 16'h0002, 16'hFFFD);
    div16(3'd6, 16'hFFF9, 16'h0002, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
